axi_rd_responder: RTL and testbench



---
 rtl/axi_rd_pkg.sv | 46 ++++
 rtl/axi_rd_responder_if.sv | 29 ++
 rtl/axi_rd_buf2.sv | 50 +++++
 rtl/axi_rd_responder.sv | 129 ++++++++++++
 tb/tb_axi_rd_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI4 read responder.
// Contents: burst type and response encodings, the responder state enum,
// and next_addr(), which steps a byte address by one beat for any burst type.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_SLVERR = 2'd2
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Address arithmetic is done at this width; callers cast in and out.
    localparam int NA_W = 32;

    // Address of the beat that follows 'addr'. A WRAP window is aligned to its
    // own size, so the boundary computed from any address inside the window
    // matches the one computed from the burst start address.
    function automatic logic [NA_W-1:0] next_addr(input logic [NA_W-1:0] addr,
                                                  input logic [1:0]      burst,
                                                  input logic [7:0]      len,
                                                  input logic [2:0]      size);
        logic [NA_W-1:0] inc;
        logic [NA_W-1:0] win;
        logic [NA_W-1:0] base;
        inc  = NA_W'(1) << size;
        win  = (NA_W'(len) + NA_W'(1)) << size;
        base = addr & ~(win - NA_W'(1));
        case (burst)
            BURST_INCR: next_addr = addr + inc;
            BURST_WRAP: next_addr = base | ((addr + inc) & (win - NA_W'(1)));
            default:    next_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read-address and read-data channel bundle.
// master: drives AR request fields, arvalid and rready.
// slave : drives arready and the R beat (rdata, rresp, rlast, rvalid).
interface axi_rd_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [1:0]            arburst;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arburst, arlen, arsize, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arburst, arlen, arsize, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_buf2.sv
// Two-entry FIFO holding R beats ({data, resp, last}).
// Ports: clk, rst (sync, active-high, clears pointers/occupancy),
// push_i/din_i write side, pop_i/dout_o read side (dout_o is the head entry),
// full_o/empty_o status. Push together with pop on a full buffer is accepted.
module axi_rd_buf2 #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] ent_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = ent_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) wptr_q <= ~wptr_q;
            if (do_pop)  rptr_q <= ~rptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) ent_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel slave serving one burst at a time from a synchronous
// single-port memory (read data arrives the cycle after mem_ren).
// Ports: clk, rst (sync, active-high); s_axi (AR/R channels, slave modport);
// mem_ren/mem_raddr word read request; mem_rdata returned word.
// FIXED, INCR and WRAP bursts are supported; malformed requests return
// arlen+1 SLVERR beats with zero data and never touch the memory.
module axi_rd_responder
    import axi_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = ADDR_WIDTH - $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_rd_responder_if.slave     s_axi,
    output logic                  mem_ren,
    output logic [MEM_AW-1:0]     mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int         BYTE_SH  = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_SH);
    localparam int         PW       = DATA_WIDTH + 3;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [1:0]            burst_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic                  err_q;
    logic [8:0]            issued_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic                  ar_hs;
    logic                  ar_err;
    logic                  issue;
    logic                  pop;
    logic                  last_hs;
    logic [2:0]            occ_sum;
    logic [1:0]            occ;
    logic                  buf_full;
    logic                  buf_empty;
    logic [PW-1:0]         buf_din;
    logic [PW-1:0]         buf_dout;
    resp_e                 push_resp;

    assign s_axi.arready = (state_q == ST_IDLE) && !rst;
    assign ar_hs         = s_axi.arready && s_axi.arvalid;

    assign ar_err = (s_axi.arburst == BURST_RSVD) ||
                    (s_axi.arsize > MAX_SIZE) ||
                    ((s_axi.arburst == BURST_WRAP) &&
                     !((s_axi.arlen == 8'd1) || (s_axi.arlen == 8'd3) ||
                       (s_axi.arlen == 8'd7) || (s_axi.arlen == 8'd15)));

    // Credit check: entries held plus the read in flight, less the beat
    // leaving this cycle, must leave room for one more.
    assign occ     = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
    assign pop     = s_axi.rvalid && s_axi.rready;
    assign occ_sum = 3'(occ) + 3'(inflight_q) - 3'(pop);
    assign issue   = !rst && (state_q == ST_BURST) &&
                     (issued_q <= {1'b0, len_q}) && (occ_sum < 3'd2);

    // Errored bursts still consume issue slots so their beats keep cadence.
    assign mem_ren   = issue && !err_q;
    assign mem_raddr = addr_q[ADDR_WIDTH-1:BYTE_SH];
    assign addr_d    = ADDR_WIDTH'(next_addr(NA_W'(addr_q), burst_q, len_q, size_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            err_q           <= 1'b0;
            issued_q        <= 9'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (issued_q == {1'b0, len_q});
            case (state_q)
                ST_IDLE: begin
                    if (ar_hs) begin
                        state_q  <= ST_BURST;
                        err_q    <= ar_err;
                        issued_q <= 9'd0;
                    end
                end
                ST_BURST: begin
                    if (issue)   issued_q <= issued_q + 9'd1;
                    if (last_hs) state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            addr_q  <= s_axi.araddr;
            burst_q <= s_axi.arburst;
            len_q   <= s_axi.arlen;
            size_q  <= s_axi.arsize;
        end else if (issue) begin
            addr_q  <= addr_d;
        end
    end

    assign push_resp = err_q ? RESP_SLVERR : RESP_OKAY;
    assign buf_din   = {(err_q ? {DATA_WIDTH{1'b0}} : mem_rdata), push_resp, inflight_last_q};

    axi_rd_buf2 #(.W(PW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (buf_din),
        .pop_i   (pop),
        .dout_o  (buf_dout),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Outputs read as zero whenever no beat is held.
    assign s_axi.rvalid = !buf_empty;
    assign s_axi.rdata  = buf_empty ? '0 : buf_dout[PW-1:3];
    assign s_axi.rresp  = buf_empty ? 2'd0 : buf_dout[2:1];
    assign s_axi.rlast  = !buf_empty && buf_dout[0];
    assign last_hs      = pop && s_axi.rlast;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed bursts from the test
// plan followed by randomized bursts, all compared against an address/beat
// model derived directly from the burst rules.
module tb_axi_rd_responder;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int MAW = 14;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_ren;
    logic [MAW-1:0] mem_raddr;
    logic [DW-1:0]  mem_rdata;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    axi_rd_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

    axi_rd_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axi     (s_axi),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] word_val(input logic [MAW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: data valid the cycle after mem_ren, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_ren ? word_val(mem_raddr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte address of beat i, from the burst rules.
    function automatic logic [15:0] model_addr(input logic [15:0] start, input logic [1:0] burst,
                                               input int len, input int size, input int i);
        int bytes, win, base, s;
        bytes = 1 << size;
        s     = int'(start);
        case (burst)
            2'd1: return 16'(s + i * bytes);
            2'd2: begin
                win  = (len + 1) * bytes;
                base = s - (s % win);
                return 16'(base + ((s - base + i * bytes) % win));
            end
            default: return start;
        endcase
    endfunction

    function automatic bit model_err(input logic [1:0] burst, input int len, input int size);
        return (burst == 2'd3) || (size > 2) ||
               ((burst == 2'd2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // mode 0: rready held 1 (cadence checked); 1: rready 1,0,0,...; 2: random.
    task automatic run_burst(input string name, input logic [15:0] addr, input logic [1:0] burst,
                             input int len, input int size, input int mode);
        bit          err, stalled, done;
        int          n_iss, n_beat, k, ren_cnt, wait_c;
        logic [31:0] pdata, edata;
        logic [1:0]  presp;
        logic        plast;
        logic [15:0] ea;
        err = model_err(burst, len, size);
        wait_c = 0;
        while (!s_axi.arready && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        if (!s_axi.arready) begin
            check({name, " arready_wait"}, 64'(s_axi.arready), 64'd1);
            return;
        end
        s_axi.araddr  = addr;
        s_axi.arburst = burst;
        s_axi.arlen   = 8'(len);
        s_axi.arsize  = 3'(size);
        s_axi.arvalid = 1'b1;
        s_axi.rready  = (mode == 0);
        n_iss = 0; n_beat = 0; k = 0; ren_cnt = 0;
        stalled = 0; done = 0;
        pdata = '0; presp = '0; plast = 1'b0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
            s_axi.arvalid = 1'b0;
            case (mode)
                0:       s_axi.rready = 1'b1;
                1:       s_axi.rready = ((k % 3) == 1);
                default: s_axi.rready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (!err) check({name, " outstanding<=2"}, 64'(n_iss - n_beat <= 2), 64'd1);
            if (mem_ren) begin
                if (err) ren_cnt++;
                else begin
                    ea = model_addr(addr, burst, len, size, n_iss);
                    check({name, " mem_raddr"}, 64'(mem_raddr), 64'(ea[15:2]));
                    if (mode == 0) check({name, " issue_cycle"}, 64'(k), 64'(n_iss + 1));
                end
                n_iss++;
            end
            if (stalled) begin
                check({name, " hold_rvalid"}, 64'(s_axi.rvalid), 64'd1);
                check({name, " hold_rdata"}, 64'(s_axi.rdata), 64'(pdata));
                check({name, " hold_rresp"}, 64'(s_axi.rresp), 64'(presp));
                check({name, " hold_rlast"}, 64'(s_axi.rlast), 64'(plast));
            end
            if (s_axi.rvalid) begin
                if (n_beat > len) check({name, " extra_beat"}, 64'(n_beat), 64'(len));
                pdata = s_axi.rdata; presp = s_axi.rresp; plast = s_axi.rlast;
                if (s_axi.rready) begin
                    ea    = model_addr(addr, burst, len, size, n_beat);
                    edata = err ? 32'd0 : word_val(ea[15:2]);
                    check({name, " rdata"}, 64'(s_axi.rdata), 64'(edata));
                    check({name, " rresp"}, 64'(s_axi.rresp), err ? 64'd2 : 64'd0);
                    check({name, " rlast"}, 64'(s_axi.rlast), 64'(n_beat == len));
                    if (mode == 0) check({name, " beat_cycle"}, 64'(k), 64'(n_beat + 3));
                    n_beat++;
                    if (s_axi.rlast) done = 1;
                end
                stalled = !s_axi.rready;
            end else begin
                stalled = 0;
            end
        end
        check({name, " beat_count"}, 64'(n_beat), 64'(len + 1));
        if (err) check({name, " no_mem_ren"}, 64'(ren_cnt), 64'd0);
        @(negedge clk);
        s_axi.rready = 1'b0;
        check({name, " arready_back"}, 64'(s_axi.arready), 64'd1);
        check({name, " rvalid_idle"}, 64'(s_axi.rvalid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " arready"}, 64'(s_axi.arready), 64'd0);
        check({name, " rvalid"}, 64'(s_axi.rvalid), 64'd0);
        check({name, " rlast"}, 64'(s_axi.rlast), 64'd0);
        check({name, " rresp"}, 64'(s_axi.rresp), 64'd0);
        check({name, " rdata"}, 64'(s_axi.rdata), 64'd0);
        check({name, " mem_ren"}, 64'(mem_ren), 64'd0);
    endtask

    initial begin
        logic [1:0]  b;
        int          l, sz;
        logic [15:0] a;
        rst = 1'b1;
        s_axi.araddr = '0; s_axi.arburst = '0; s_axi.arlen = '0; s_axi.arsize = '0;
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("post_reset arready", 64'(s_axi.arready), 64'd1);

        run_burst("incr",      16'h0010, 2'd1, 3, 2, 0);
        run_burst("wrap",      16'h0018, 2'd2, 3, 2, 0);
        run_burst("fixed",     16'h0020, 2'd0, 2, 2, 0);
        run_burst("backpress", 16'h0040, 2'd1, 7, 2, 1);
        run_burst("err_burst", 16'h0030, 2'd3, 1, 2, 0);
        run_burst("err_size",  16'h0030, 2'd1, 1, 3, 0);
        run_burst("err_wlen",  16'h0030, 2'd2, 2, 2, 1);
        run_burst("incr_top",  16'hFFF8, 2'd1, 3, 2, 0);
        run_burst("wrap8",     16'h0134, 2'd2, 7, 2, 2);

        // Reset in the middle of a long burst.
        s_axi.araddr = 16'h0100; s_axi.arburst = 2'd1; s_axi.arlen = 8'd15;
        s_axi.arsize = 3'd2; s_axi.arvalid = 1'b1; s_axi.rready = 1'b1;
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        #1;
        check("mid_rst arready_after", 64'(s_axi.arready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            #1;
            check("mid_rst no_rvalid", 64'(s_axi.rvalid), 64'd0);
            check("mid_rst no_mem_ren", 64'(mem_ren), 64'd0);
        end
        s_axi.rready = 1'b0;
        run_burst("single", 16'h0200, 2'd1, 0, 2, 0);

        for (int r = 0; r < 24; r++) begin
            b  = 2'($urandom_range(0, 3));
            sz = $urandom_range(0, 3);
            if (b == 2'd2 && $urandom_range(0, 3) != 0) begin
                l = (2 << $urandom_range(0, 3)) - 1;
            end else begin
                l = $urandom_range(0, 15);
            end
            a = 16'($urandom) & ~16'((1 << sz) - 1);
            run_burst("rand", a, b, l, sz, r % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
